rw_ram_param: RTL and testbench
===============================

RW_RAM_PARAM -- requirements
Module: rw_ram_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width in bits.
REQ-002 SHALL have parameter DEPTH, default 96, number of words.
REQ-003 SHALL have parameter ADDR_W, default 7, address width; DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter INIT0, default 8'h33 (zero-extended to DATA_W), word 0 init value.
REQ-005 SHALL have parameter INIT1, default 8'h22 (zero-extended to DATA_W), word 1 init value.
REQ-006 SHALL have parameter READ_REG, default 0; 0 = combinational read, 1 = registered read.
REQ-007 clk  input  1  sole clock, all state on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 init_req  input  1  one-cycle request to re-run the memory initialisation sequence.
REQ-010 write  input  1  write strobe.
REQ-011 read  input  1  read strobe.
REQ-012 address  input  ADDR_W  word address for read/write.
REQ-013 data_in  input  DATA_W  write data.
REQ-014 data_out  output  DATA_W  read data.
REQ-015 rd_valid  output  1  data_out holds valid read data.
REQ-016 busy  output  1  initialisation in progress; accesses ignored.
REQ-017 addr_err  output  1  sticky flag: an access used address >= DEPTH.

Function
REQ-018 SHALL implement FSM states INIT and IDLE; busy = (state == INIT).
REQ-019 In INIT, SHALL write one word per cycle at counter address: word 0 = INIT0, word 1 = INIT1, all others 0; counter 0..DEPTH-1, then IDLE; INIT lasts exactly DEPTH cycles.
REQ-020 In IDLE, init_req SHALL move to INIT with counter 0 on the next edge and clear addr_err; a write in the same cycle is dropped.
REQ-021 init_req during INIT SHALL be ignored (no restart).
REQ-022 write and read while busy SHALL be ignored: no memory change, rd_valid 0, addr_err unchanged.
REQ-023 In IDLE, write with address < DEPTH SHALL store data_in at the next rising edge.
REQ-024 Any read or write in IDLE with address >= DEPTH SHALL not touch memory and SHALL set addr_err on the next edge; addr_err holds until reset or accepted init_req.
REQ-025 READ_REG=0: data_out = mem[address] combinationally when IDLE and address < DEPTH, else 0; rd_valid = read & IDLE & address < DEPTH.
REQ-026 READ_REG=1: read accepted in cycle N SHALL give data_out and rd_valid=1 in cycle N+1; otherwise rd_valid=0 and data_out holds its last value.
REQ-027 READ_REG=1 same-address read and write in one cycle SHALL return the old (pre-write) data (read-first).
REQ-028 READ_REG=1 out-of-range read SHALL give rd_valid=0 in cycle N+1.
REQ-029 READ_REG=0 same-address read and write SHALL show old data until the edge, new data after.

Reset
REQ-030 Reset SHALL force state INIT, counter 0, busy 1, rd_valid 0, data_out 0, addr_err 0 immediately.
REQ-031 Reset asserted mid-INIT SHALL restart the sequence from counter 0 after deassertion.
REQ-032 Memory array SHALL NOT be asynchronously reset; contents are defined only via the INIT sequence.

Structure
REQ-033 Package rw_ram_pkg SHALL hold the state enum (INIT, IDLE) and default constants DATA_W_DEF=8, DEPTH_DEF=96, INIT0_DEF=8'h33, INIT1_DEF=8'h22.
REQ-034 Init FSM and counter SHALL live in sub-module rw_ram_init_seq (outputs: busy, init write enable, init address, init data).

Verification
REQ-035 Reset, release, count cycles -> busy high exactly 96 cycles; then read addr 0 = 8'h33, addr 1 = 8'h22, addr 95 = 8'h00.
REQ-036 IDLE, write 8'hA5 to addr 10, read addr 10 -> READ_REG=0: 8'hA5 same cycle; READ_REG=1: 8'hA5 with rd_valid next cycle.
REQ-037 READ_REG=1, addr 10 holds 8'hA5, write 8'h5A + read addr 10 same cycle -> 8'hA5 returned; next read -> 8'h5A.
REQ-038 Write 8'hFF to addr 100 -> addr_err=1 next cycle, no location changed, rd_valid 0 on read of addr 100; init_req clears addr_err.
REQ-039 Write addr 5 = 8'h77, pulse init_req with write addr 6 -> busy 96 cycles, addr 5 and 6 read 8'h00 afterwards.
REQ-040 Assert reset at INIT counter 40 -> outputs reset immediately; after release busy lasts full 96 cycles.

Source files
------------

// File: rtl/rw_ram_pkg.sv
// Shared types and default constants for the parameterised read/write RAM.
package rw_ram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;

  localparam int         DATA_W_DEF = 8;
  localparam int         DEPTH_DEF  = 96;
  localparam logic [7:0] INIT0_DEF  = 8'h33;
  localparam logic [7:0] INIT1_DEF  = 8'h22;

endpackage

// File: rtl/rw_ram_init_seq.sv
// Initialisation sequencer: walks every word once after reset or init_req.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   INIT  | writing one init word per cycle at cnt_q, 0..DEPTH-1 (busy)
//   IDLE  | memory ready; user accesses accepted; waits for init_req
module rw_ram_init_seq
  import rw_ram_pkg::*;
#(
  parameter int                DATA_W = DATA_W_DEF,
  parameter int                DEPTH  = DEPTH_DEF,
  parameter int                ADDR_W = 7,
  parameter logic [DATA_W-1:0] INIT0  = DATA_W'(INIT0_DEF),
  parameter logic [DATA_W-1:0] INIT1  = DATA_W'(INIT1_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_req,
  output logic              busy,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic [DATA_W-1:0] init_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // State and counter register; reset restarts the sequence from word 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: INIT runs exactly DEPTH cycles; init_req only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (init_req) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy      = (state_q == INIT);
  assign init_we   = busy;
  assign init_addr = cnt_q;
  assign init_data = (cnt_q == '0)         ? INIT0 :
                     (cnt_q == ADDR_W'(1)) ? INIT1 : '0;

endmodule

// File: rtl/rw_ram_param.sv
// Single-port RAM with a self-initialisation sequence, range checking and
// selectable combinational or registered (read-first) read path.
module rw_ram_param
  import rw_ram_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                DEPTH    = DEPTH_DEF,
  parameter int                ADDR_W   = 7,
  parameter logic [DATA_W-1:0] INIT0    = DATA_W'(INIT0_DEF),
  parameter logic [DATA_W-1:0] INIT1    = DATA_W'(INIT1_DEF),
  parameter int                READ_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_req,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              addr_err
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_data;
  logic              idle;
  logic              in_range;
  logic              user_we;
  logic              rd_ok;

  rw_ram_init_seq #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .INIT0  (INIT0),
    .INIT1  (INIT1)
  ) u_init_seq (
    .clk       (clk),
    .reset     (reset),
    .init_req  (init_req),
    .busy      (busy),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data)
  );

  assign idle     = ~busy;
  assign in_range = ({1'b0, address} < DEPTH_C);
  // A write coinciding with an accepted init_req is dropped.
  assign user_we  = idle & write & in_range & ~init_req;
  assign rd_ok    = idle & read & in_range;

  // Memory array: no reset, contents come only from the init sequence and writes.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= init_data;
    end else if (user_we) begin
      mem[address] <= data_in;
    end
  end

  // Sticky range error; cleared only by reset or an accepted init_req.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_err <= 1'b0;
    end else if (idle && init_req) begin
      addr_err <= 1'b0;
    end else if (idle && (read || write) && !in_range) begin
      addr_err <= 1'b1;
    end
  end

  if (READ_REG == 0) begin : g_comb_rd
    // Combinational read: shows pre-write data until the write edge.
    assign data_out = (idle && in_range) ? mem[address] : '0;
    assign rd_valid = rd_ok;
  end else begin : g_reg_rd
    // Registered read-first: samples the array before the same-edge write lands.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        data_out <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_ok;
        if (rd_ok) begin
          data_out <= mem[address];
        end
      end
    end
  end

endmodule

// File: tb/tb_rw_ram_param.sv
// Directed bench driving a combinational-read and a registered-read instance
// with the same stimulus.
module tb_rw_ram_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       init_req;
  logic       write;
  logic       read;
  logic [6:0] address;
  logic [7:0] data_in;

  logic [7:0] dout0, dout1;
  logic       rv0, rv1, busy0, busy1, aerr0, aerr1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rw_ram_param #(.READ_REG(0)) dut0 (
    .clk(clk), .reset(reset), .init_req(init_req), .write(write), .read(read),
    .address(address), .data_in(data_in), .data_out(dout0), .rd_valid(rv0),
    .busy(busy0), .addr_err(aerr0)
  );

  rw_ram_param #(.READ_REG(1)) dut1 (
    .clk(clk), .reset(reset), .init_req(init_req), .write(write), .read(read),
    .address(address), .data_in(data_in), .data_out(dout1), .rd_valid(rv1),
    .busy(busy1), .addr_err(aerr1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic idle_inputs();
    init_req = 1'b0; write = 1'b0; read = 1'b0; address = '0; data_in = '0;
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    write = 1'b1; address = a; data_in = d;
    @(negedge clk); #1;
    write = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [6:0] a, input logic [7:0] exp);
    read = 1'b1; address = a; #1;
    chk({tag, " comb data"}, dout0, exp);
    chk({tag, " comb valid"}, rv0, 1'b1);
    @(negedge clk); #1;
    read = 1'b0;
    chk({tag, " reg data"}, dout1, exp);
    chk({tag, " reg valid"}, rv1, 1'b1);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy0 && n < 200) begin
      n++;
      @(negedge clk); #1;
    end
  endtask

  initial begin
    int n;
    idle_inputs();
    reset = 1'b1;
    #1;
    chk("rst busy0", busy0, 1'b1);
    chk("rst busy1", busy1, 1'b1);
    chk("rst valid0", rv0, 1'b0);
    chk("rst valid1", rv1, 1'b0);
    chk("rst dout0", dout0, 8'h00);
    chk("rst dout1", dout1, 8'h00);
    chk("rst aerr0", aerr0, 1'b0);
    chk("rst aerr1", aerr1, 1'b0);

    @(negedge clk); @(negedge clk); #1;
    reset = 1'b0;
    count_busy(n);
    chk("init busy cycles", n, 96);
    chk("init busy1 done", busy1, 1'b0);

    rd("w0", 7'd0, 8'h33);
    rd("w1", 7'd1, 8'h22);
    rd("w95", 7'd95, 8'h00);

    // Plain write then read back.
    wr(7'd10, 8'hA5);
    rd("w10", 7'd10, 8'hA5);

    // Same-address read + write: old data before the edge / from the register.
    read = 1'b1; write = 1'b1; address = 7'd10; data_in = 8'h5A; #1;
    chk("rw comb old", dout0, 8'hA5);
    @(negedge clk); #1;
    read = 1'b0; write = 1'b0;
    chk("rw reg old", dout1, 8'hA5);
    chk("rw reg valid", rv1, 1'b1);
    rd("w10 new", 7'd10, 8'h5A);

    // Out-of-range write and read.
    write = 1'b1; address = 7'd100; data_in = 8'hFF; #1;
    chk("oor aerr before", aerr0, 1'b0);
    @(negedge clk); #1;
    write = 1'b0;
    chk("oor aerr0", aerr0, 1'b1);
    chk("oor aerr1", aerr1, 1'b1);
    read = 1'b1; address = 7'd100; #1;
    chk("oor comb valid", rv0, 1'b0);
    chk("oor comb data", dout0, 8'h00);
    @(negedge clk); #1;
    read = 1'b0;
    chk("oor reg valid", rv1, 1'b0);
    chk("oor reg hold", dout1, 8'h5A);
    rd("oor w4", 7'd4, 8'h00);
    rd("oor w0", 7'd0, 8'h33);
    rd("oor w10", 7'd10, 8'h5A);
    chk("oor aerr sticky", aerr0, 1'b1);

    // init_req with a dropped write; re-run also clears addr_err.
    wr(7'd5, 8'h77);
    rd("w5", 7'd5, 8'h77);
    init_req = 1'b1; write = 1'b1; address = 7'd6; data_in = 8'h99;
    @(negedge clk); #1;
    idle_inputs();
    chk("reinit busy", busy0, 1'b1);
    chk("reinit aerr0", aerr0, 1'b0);
    chk("reinit aerr1", aerr1, 1'b0);
    n = 0;
    while (busy0 && n < 200) begin
      if (n == 50) begin
        // Accesses and a second init_req while busy must all be ignored.
        init_req = 1'b1; write = 1'b1; read = 1'b1; address = 7'd7; data_in = 8'h11; #1;
        chk("busy comb valid", rv0, 1'b0);
        chk("busy comb data", dout0, 8'h00);
      end
      n++;
      @(negedge clk); #1;
      if (n == 51) begin
        idle_inputs();
        chk("busy reg valid", rv1, 1'b0);
      end
    end
    chk("reinit busy cycles", n, 96);
    rd("after w5", 7'd5, 8'h00);
    rd("after w6", 7'd6, 8'h00);
    rd("after w7", 7'd7, 8'h00);
    rd("after w0", 7'd0, 8'h33);

    // Reset asserted mid-INIT at counter 40.
    init_req = 1'b1;
    @(negedge clk); #1;
    idle_inputs();
    n = 0;
    while (busy0 && n < 40) begin
      n++;
      @(negedge clk); #1;
    end
    chk("mid busy", busy0, 1'b1);
    chk("mid reg hold", dout1, 8'h33);
    #1 reset = 1'b1;
    #1;
    chk("mid rst busy", busy1, 1'b1);
    chk("mid rst dout1", dout1, 8'h00);
    chk("mid rst valid1", rv1, 1'b0);
    chk("mid rst aerr", aerr1, 1'b0);
    @(negedge clk); @(negedge clk); #1;
    reset = 1'b0;
    count_busy(n);
    chk("mid rst busy cycles", n, 96);
    rd("final w0", 7'd0, 8'h33);
    rd("final w1", 7'd1, 8'h22);
    rd("final w10", 7'd10, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
